// File: rtl/gcbp_pkg.sv
// Shared definitions for the GCBP motion-match scheduler: sizes, slot-location
// width, FSM state encoding and the ceiling-log2 helper used to size indices.
package gcbp_pkg;

  // Number of bits needed to index 'depth' distinct items (minimum 0).
  function automatic int CLogB2(input int depth);
    int bits;
    bits = 0;
    for (int v = depth - 1; v > 0; v = v >> 1) begin
      bits++;
    end
    return bits;
  endfunction

  localparam int C_NUM_SUBIMAGES = 16;                      // 4 rows x 4 columns
  localparam int C_IDX_BITS      = CLogB2(C_NUM_SUBIMAGES);
  localparam int C_MV_W          = 8;                       // signed dx / dy width
  localparam int C_SUM_W         = C_MV_W + C_IDX_BITS;     // 16 * 128 fits without overflow
  localparam int C_LOC_W         = 2;                       // BRAM slot location width
  localparam int C_TIMEOUT       = 4096;                    // cycles allowed per job result
  localparam int C_TMO_W         = CLogB2(C_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROTATE = 3'd1,
    S_SETTLE = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_REPORT = 3'd5
  } state_e;

endpackage

// File: rtl/gcbp_mv_accum.sv
// Global-motion accumulator: signed dx/dy sums and accepted-result count.
// Cleared at the start of each matching frame, added to once per good result.
module gcbp_mv_accum
  import gcbp_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_clr,
  input  logic               i_add,
  input  logic [C_MV_W-1:0]  i_dx,
  input  logic [C_MV_W-1:0]  i_dy,
  output logic [C_SUM_W-1:0] o_dx_sum,
  output logic [C_SUM_W-1:0] o_dy_sum,
  output logic [C_IDX_BITS:0] o_cnt
);

  logic [C_SUM_W-1:0]  dx_sum_q;
  logic [C_SUM_W-1:0]  dy_sum_q;
  logic [C_IDX_BITS:0] cnt_q;
  logic [C_SUM_W-1:0]  dx_ext;
  logic [C_SUM_W-1:0]  dy_ext;

  // Motion components are two's complement, so widen by replicating the sign bit.
  assign dx_ext = {{(C_SUM_W - C_MV_W){i_dx[C_MV_W-1]}}, i_dx};
  assign dy_ext = {{(C_SUM_W - C_MV_W){i_dy[C_MV_W-1]}}, i_dy};

  // Sums and count: clear wins over add; values hold otherwise.
  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      dx_sum_q <= '0;
      dy_sum_q <= '0;
      cnt_q    <= '0;
    end else if (i_clr) begin
      dx_sum_q <= '0;
      dy_sum_q <= '0;
      cnt_q    <= '0;
    end else if (i_add) begin
      dx_sum_q <= dx_sum_q + dx_ext;
      dy_sum_q <= dy_sum_q + dy_ext;
      cnt_q    <= cnt_q + {{C_IDX_BITS{1'b0}}, 1'b1};
    end
  end

  assign o_dx_sum = dx_sum_q;
  assign o_dy_sum = dy_sum_q;
  assign o_cnt    = cnt_q;

endmodule

// File: rtl/gcbp_match_sched.sv
// Per-frame motion-match sequencer: rotates the BRAM slots on each committed
// frame, latches the curr/prev slots, issues the 16 sub-image jobs one at a
// time and reports the summed global motion vector.
module gcbp_match_sched
  import gcbp_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_frame_written,
  input  logic [C_LOC_W-1:0]    i_curr_loc,
  input  logic [C_LOC_W-1:0]    i_prev_loc,
  output logic                  o_rotate,
  output logic                  o_job_valid,
  input  logic                  i_job_ready,
  output logic [C_IDX_BITS-1:0] o_job_idx,
  output logic [C_LOC_W-1:0]    o_job_curr_loc,
  output logic [C_LOC_W-1:0]    o_job_prev_loc,
  input  logic                  i_res_valid,
  input  logic [C_IDX_BITS-1:0] i_res_idx,
  input  logic                  i_res_err,
  input  logic [C_MV_W-1:0]     i_res_dx,
  input  logic [C_MV_W-1:0]     i_res_dy,
  output logic                  o_gmv_valid,
  output logic [C_SUM_W-1:0]    o_gmv_dx_sum,
  output logic [C_SUM_W-1:0]    o_gmv_dy_sum,
  output logic [C_IDX_BITS:0]   o_gmv_cnt,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam logic [C_IDX_BITS-1:0] C_LAST_IDX = C_IDX_BITS'(C_NUM_SUBIMAGES - 1);
  localparam logic [C_TMO_W-1:0]    C_TMO_LAST = C_TMO_W'(C_TIMEOUT - 1);

  state_e                state_q;
  logic                  rotate_q;
  logic                  job_valid_q;
  logic [C_IDX_BITS-1:0] idx_q;
  logic [C_LOC_W-1:0]    curr_loc_q;
  logic [C_LOC_W-1:0]    prev_loc_q;
  logic                  gmv_valid_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic [C_TMO_W-1:0]    tmo_q;
  logic [1:0]            frames_q;
  logic [1:0]            frames_d;

  logic accept;
  logic timeout;
  logic fw_dropped;

  // Only a result for the job in flight counts; stale indices are ignored.
  assign accept     = (state_q == S_WAIT) && i_res_valid && (i_res_idx == idx_q);
  assign timeout    = (tmo_q == C_TMO_LAST);
  assign fw_dropped = i_frame_written && (state_q != S_IDLE) && (state_q != S_REPORT);
  // Saturating frame count: matching needs two frames so prev holds real data.
  assign frames_d   = (frames_q == 2'b11) ? frames_q : frames_q + 2'd1;

  // Sequencing FSM with registered strobes, job handshake and timeout counter.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q     <= S_IDLE;
      rotate_q    <= 1'b0;
      job_valid_q <= 1'b0;
      idx_q       <= '0;
      curr_loc_q  <= '0;
      prev_loc_q  <= '0;
      gmv_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      tmo_q       <= '0;
      frames_q    <= '0;
    end else begin
      rotate_q    <= 1'b0;
      gmv_valid_q <= 1'b0;
      overrun_q   <= fw_dropped;
      case (state_q)
        S_IDLE: begin
          if (i_frame_written) begin
            state_q  <= S_ROTATE;
            rotate_q <= 1'b1;
            busy_q   <= 1'b1;
            frames_q <= frames_d;
          end
        end
        S_ROTATE: begin
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          // The decoder has rotated by now, so its slot outputs are stable.
          curr_loc_q <= i_curr_loc;
          prev_loc_q <= i_prev_loc;
          idx_q      <= '0;
          if (frames_q < 2'd2) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q     <= S_ISSUE;
            job_valid_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (i_job_ready) begin
            state_q     <= S_WAIT;
            job_valid_q <= 1'b0;
            tmo_q       <= '0;
          end
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle is still accepted.
          if (accept || timeout) begin
            if (idx_q == C_LAST_IDX) begin
              state_q     <= S_REPORT;
              gmv_valid_q <= 1'b1;
            end else begin
              state_q     <= S_ISSUE;
              job_valid_q <= 1'b1;
              idx_q       <= idx_q + {{(C_IDX_BITS-1){1'b0}}, 1'b1};
            end
          end else begin
            tmo_q <= tmo_q + {{(C_TMO_W-1){1'b0}}, 1'b1};
          end
        end
        S_REPORT: begin
          if (i_frame_written) begin
            state_q  <= S_ROTATE;
            rotate_q <= 1'b1;
            frames_q <= frames_d;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          job_valid_q <= 1'b0;
        end
      endcase
    end
  end

  gcbp_mv_accum u_accum (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_clr    (state_q == S_SETTLE),
    .i_add    (accept && !i_res_err),
    .i_dx     (i_res_dx),
    .i_dy     (i_res_dy),
    .o_dx_sum (o_gmv_dx_sum),
    .o_dy_sum (o_gmv_dy_sum),
    .o_cnt    (o_gmv_cnt)
  );

  assign o_rotate       = rotate_q;
  assign o_job_valid    = job_valid_q;
  assign o_job_idx      = idx_q;
  assign o_job_curr_loc = curr_loc_q;
  assign o_job_prev_loc = prev_loc_q;
  assign o_gmv_valid    = gmv_valid_q;
  assign o_busy         = busy_q;
  assign o_overrun      = overrun_q;

endmodule
